// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN to build it in first-word-fall-through read mode.
module sync_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic                       r_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok    = w_en && !full;
  assign rd_ok    = r_en && !empty;
  assign rptr_nxt = rptr + AW'(rd_ok);

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is freshly written when the FIFO is empty after this edge's pop.
  logic head_new;
  assign head_new = wr_ok && (empty || (count == CW'(1) && rd_ok));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      data_out     <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      empty        <= count_nxt == '0;
      full         <= count_nxt == CW'(DEPTH);
      almost_full  <= count_nxt >= CW'(AF_LEVEL);
      almost_empty <= count_nxt <= CW'(AE_LEVEL);
      overflow     <= w_en && full;
      underflow    <= r_en && empty;
`ifdef SYNC_FIFO_FWFT_EN
      if (head_new)
        data_out <= data_in;
      else if (count_nxt != '0)
        data_out <= mem[rptr_nxt];
`else
      if (rd_ok) data_out <= mem[rptr];
`endif
    end
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. Adds programmable almost-full and almost-empty thresholds, an occupancy count, and one-cycle overflow/underflow error pulses. An optional first-word-fall-through read mode is compiled in by macro. It sits between a producer and a consumer in the same clock domain and is driven and sampled through the existing clocking-block style of bench.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
w_en  input  1  write request
r_en  input  1  read request
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, overflow=0, underflow=0. Reset overrides w_en and r_en in the same cycle. A mid-stream reset discards all contents. Memory contents are not cleared.
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- All flags and count are registered, and all are derived from the post-update count.
- Write accepted iff w_en && !full (full as registered at the edge): mem[wptr] <= data_in, wptr++.
- Read accepted iff r_en && !empty: rptr++.
- Standard mode read latency: data_out <= mem[rptr] at the accepting edge, so it is valid 1 cycle after r_en is sampled. data_out holds its value when no read is accepted.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous w_en && r_en:
  - not empty and not full: both accepted, count unchanged.
  - full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
  - empty: write accepted, read rejected, underflow pulses, count becomes 1, data_out unchanged.
- overflow = 1 for exactly the cycle after a rejected write. underflow = 1 for exactly the cycle after a rejected read. Neither is sticky.
- There is no FSM beyond pointer/count state. Occupancy states EMPTY, PARTIAL and FULL are implied by count.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through. data_out continuously presents mem[rptr] while !empty, with zero read latency; r_en acknowledges/pops the word.
  - The first write into an empty FIFO appears on data_out the cycle after the write edge.
  - While empty, data_out holds its last value.
  - Flags, count, overflow and underflow behave identically to standard mode.
- Undefined: standard mode, 1-cycle registered read as above.

Test Plan:
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
1. Reset then idle 3 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0x00, no error pulses.
2. Write 0x01..0x10 (16 words), then 1 extra write of 0xAA -> almost_full rises when count=14; full=1 at count=16; extra write gives overflow=1 for one cycle with count staying 16. Then 16 reads return 0x01..0x10 in order and 0xAA is never returned; empty=1 at the end.
3. Read while empty -> underflow=1 for one cycle, data_out unchanged, count=0.
4. Fill 16, then assert w_en and r_en together for 1 cycle with data_in=0x55 -> read of the oldest word accepted, write rejected, overflow=1, count=15. Separately, from empty, do a simultaneous write of 0x77 and a read -> count=1, underflow=1; the next read returns 0x77.
5. Wrap-around: 40 cycles of simultaneous write/read at steady count=8, with an incrementing data pattern -> output sequence is exactly the input delayed by 8 words, with no flag changes and no errors.
6. Assert rst mid-stream at count=9 with w_en=1 -> next cycle count=0, empty=1; the written word is discarded. With SYNC_FIFO_FWFT_EN defined, rerun scenario 2: each word appears on data_out with no read latency.
